dual_issue_scheduler: RTL and testbench

// Issue controller for the two-wide datapath. Accepts instruction pairs from the

---
 rtl/dual_issue_scheduler.sv | 150 +++++++++++++++
 tb/tb_dual_issue_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_scheduler.sv
// Two-wide issue controller: 2-entry issue buffer, pairwise hazard checks and a
// per-register load-latency countdown scoreboard driving registered slot enables.
module dual_issue_scheduler #(
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned NREGS    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_ins0,
    input  logic [31:0] fetch_ins1,
    input  logic        fetch_ins1_valid,
    output logic        fetch_ready,
    input  logic        flush,
    output logic [31:0] instruction0,
    output logic [31:0] instruction1,
    output logic        datapath_1_enable,
    output logic        datapath_2_enable,
    output logic        freeze1,
    output logic        freeze2
);

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [2:0]  LAT = 3'(LOAD_LAT);

    typedef enum logic [1:0] {EMPTY, SINGLE, PAIR} occ_t;

    occ_t        state, state_nx;
    logic [31:0] b0, b1, b0_nx, b1_nx;
    logic        b0_v, b1_v;
    logic [2:0]  sb_cnt [NREGS];
    logic [NREGS-1:0] busy;
    logic        blocked0, blocked1, pair_hazard;
    logic        issue0, issue1, drain, set_load;

    function automatic logic writes_rd(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        return (ins[11:7] != 5'd0) &&
               (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
                op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111 ||
                op == 7'b1100111);
    endfunction

    function automatic logic reads_rs1(input logic [31:0] ins);
        return !(ins[6:0] == 7'b0110111 || ins[6:0] == 7'b0010111 ||
                 ins[6:0] == 7'b1101111);
    endfunction

    function automatic logic reads_rs2(input logic [31:0] ins);
        return ins[6:0] == 7'b0110011 || ins[6:0] == 7'b0100011 ||
               ins[6:0] == 7'b1100011;
    endfunction

    function automatic logic is_mem(input logic [31:0] ins);
        return ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011;
    endfunction

    function automatic logic is_ctrl(input logic [31:0] ins);
        return ins[6:0] == 7'b1100011 || ins[6:0] == 7'b1101111 ||
               ins[6:0] == 7'b1100111;
    endfunction

    assign b0_v = (state != EMPTY);
    assign b1_v = (state == PAIR);

    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            busy[i] = (sb_cnt[i] != 3'd0);
        end
    end

    always_comb begin
        blocked0 = (reads_rs1(b0) && busy[b0[19:15]]) ||
                   (reads_rs2(b0) && busy[b0[24:20]]) ||
                   (writes_rd(b0) && busy[b0[11:7]]);
        blocked1 = (reads_rs1(b1) && busy[b1[19:15]]) ||
                   (reads_rs2(b1) && busy[b1[24:20]]) ||
                   (writes_rd(b1) && busy[b1[11:7]]);
        pair_hazard = writes_rd(b0) &&
                      ((reads_rs1(b1) && b1[19:15] == b0[11:7]) ||
                       (reads_rs2(b1) && b1[24:20] == b0[11:7]) ||
                       (writes_rd(b1) && b1[11:7] == b0[11:7]));
        issue0 = b0_v && !blocked0;
        issue1 = issue0 && b1_v && !blocked1 && !pair_hazard &&
                 !is_mem(b1) && !is_ctrl(b0);
        drain  = (!b0_v || issue0) && (!b1_v || issue1);
        set_load = issue0 && !flush && b0[6:0] == 7'b0000011 && writes_rd(b0);
    end

    // Buffer occupancy next-state; a flush still completes the fetch handshake but drops the pair.
    always_comb begin
        state_nx    = state;
        b0_nx       = b0;
        b1_nx       = b1;
        fetch_ready = !rst && (flush || drain);
        if (flush) begin
            state_nx = EMPTY;
        end else if (drain) begin
            if (fetch_valid) begin
                b0_nx    = fetch_ins0;
                b1_nx    = fetch_ins1;
                state_nx = fetch_ins1_valid ? PAIR : SINGLE;
            end else begin
                state_nx = EMPTY;
            end
        end else if (issue0) begin
            b0_nx    = b1;
            state_nx = SINGLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= EMPTY;
            b0                <= NOP;
            b1                <= NOP;
            instruction0      <= NOP;
            instruction1      <= NOP;
            datapath_1_enable <= 1'b0;
            datapath_2_enable <= 1'b0;
            freeze1           <= 1'b0;
            freeze2           <= 1'b0;
        end else begin
            state             <= state_nx;
            b0                <= b0_nx;
            b1                <= b1_nx;
            datapath_1_enable <= issue0 && !flush;
            datapath_2_enable <= issue1 && !flush;
            freeze1           <= b0_v && !issue0 && !flush;
            freeze2           <= b1_v && !issue1 && !flush;
            if (issue0 && !flush) instruction0 <= b0;
            if (issue1 && !flush) instruction1 <= b1;
        end
    end

    // A fresh load overrides the countdown of its own rd; everything else counts down.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (rst) begin
                sb_cnt[i] <= 3'd0;
            end else if (set_load && b0[11:7] == 5'(i)) begin
                sb_cnt[i] <= LAT;
            end else if (sb_cnt[i] != 3'd0) begin
                sb_cnt[i] <= sb_cnt[i] - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench for dual_issue_scheduler: table-driven pair vectors plus
// hand sequences for load-use, flush and reset-during-split.
module tb_dual_issue_scheduler;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_ins0 = '0;
    logic [31:0] fetch_ins1 = '0;
    logic        fetch_ins1_valid = 1'b0;
    logic        fetch_ready;
    logic        flush = 1'b0;
    logic [31:0] instruction0, instruction1;
    logic        datapath_1_enable, datapath_2_enable, freeze1, freeze2;

    int checks   = 0;
    int failures = 0;

    dual_issue_scheduler #(.LOAD_LAT(2), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_ins0(fetch_ins0),
        .fetch_ins1(fetch_ins1), .fetch_ins1_valid(fetch_ins1_valid),
        .fetch_ready(fetch_ready), .flush(flush), .instruction0(instruction0),
        .instruction1(instruction1), .datapath_1_enable(datapath_1_enable),
        .datapath_2_enable(datapath_2_enable), .freeze1(freeze1), .freeze2(freeze2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en1, en2, f1, f2;
        logic [31:0] i0, i1;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] ins0, ins1;
        logic        v1;
        exp_t        e1, e2;
    } vec_t;

    exp_t expq[$];
    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic check_out(input string nm);
        exp_t e;
        if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s actual=empty_queue required=expectation", nm);
            return;
        end
        e = expq.pop_front();
        chk({nm, ".en1"}, 32'(datapath_1_enable), 32'(e.en1));
        chk({nm, ".en2"}, 32'(datapath_2_enable), 32'(e.en2));
        chk({nm, ".freeze1"}, 32'(freeze1), 32'(e.f1));
        chk({nm, ".freeze2"}, 32'(freeze2), 32'(e.f2));
        chk({nm, ".ins0"}, instruction0, e.i0);
        chk({nm, ".ins1"}, instruction1, e.i1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; fetch_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        expq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, NOP, NOP});
        check_out("reset");
    endtask

    task automatic offer(input logic [31:0] i0, input logic [31:0] i1, input logic v1);
        fetch_valid = 1'b1; fetch_ins0 = i0; fetch_ins1 = i1; fetch_ins1_valid = v1;
    endtask

    initial begin
        vecs[0] = '{"indep",  32'h00500093, 32'h00300113, 1'b1,
                    '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00500093, 32'h00300113},
                    '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00500093, 32'h00300113}};
        vecs[1] = '{"raw",    32'h00500093, 32'h00108133, 1'b1,
                    '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00500093, NOP},
                    '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00108133, NOP}};
        vecs[2] = '{"memmem", 32'h0000a083, 32'h0021a023, 1'b1,
                    '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000a083, NOP},
                    '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0021a023, NOP}};
        vecs[3] = '{"branch", 32'h00000463, 32'h00300113, 1'b1,
                    '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00000463, NOP},
                    '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00300113, NOP}};
        vecs[4] = '{"single", 32'h00500093, 32'h00300113, 1'b0,
                    '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00500093, NOP},
                    '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00500093, NOP}};
        vecs[5] = '{"waw",    32'h00500093, 32'h00700093, 1'b1,
                    '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00500093, NOP},
                    '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00700093, NOP}};
        vecs[6] = '{"ld_alu", 32'h0000a083, 32'h00300113, 1'b1,
                    '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0000a083, 32'h00300113},
                    '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000a083, 32'h00300113}};
        vecs[7] = '{"x0dest", 32'h00000013, 32'h00000033, 1'b1,
                    '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00000013, 32'h00000033},
                    '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00000013, 32'h00000033}};
        vecs[8] = '{"alu_ld", 32'h00500093, 32'h0001a183, 1'b1,
                    '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00500093, NOP},
                    '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0001a183, NOP}};

        for (int v = 0; v < 9; v++) begin
            do_reset();
            offer(vecs[v].ins0, vecs[v].ins1, vecs[v].v1);
            #1 chk({vecs[v].name, ".ready"}, 32'(fetch_ready), 32'd1);
            expq.push_back(vecs[v].e1);
            expq.push_back(vecs[v].e2);
            @(negedge clk);
            fetch_valid = 1'b0;
            @(negedge clk);
            check_out({vecs[v].name, ".c1"});
            @(negedge clk);
            check_out({vecs[v].name, ".c2"});
        end

        // Load-use: add waits two cycles behind lw x1.
        do_reset();
        offer(32'h0000a083, 32'h0, 1'b0);
        expq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000a083, NOP});
        expq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000a083, NOP});
        expq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000a083, NOP});
        expq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 32'h00108133, NOP});
        @(negedge clk);
        offer(32'h00108133, 32'h0, 1'b0);
        #1 chk("lu.ready_lw", 32'(fetch_ready), 32'd1);
        @(negedge clk);
        fetch_valid = 1'b0;
        check_out("lu.lw");
        @(negedge clk);
        check_out("lu.stall1");
        #1 chk("lu.ready_stall", 32'(fetch_ready), 32'd0);
        @(negedge clk);
        check_out("lu.stall2");
        @(negedge clk);
        check_out("lu.add");

        // Branch in B0 followed by a flush; the pair offered during flush is dropped.
        do_reset();
        offer(32'h00000463, 32'h00300113, 1'b1);
        expq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h00000463, NOP});
        expq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h00000463, NOP});
        expq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 32'h00000463, NOP});
        @(negedge clk);
        fetch_valid = 1'b0;
        @(negedge clk);
        check_out("fl.branch");
        flush = 1'b1;
        offer(32'h00500093, 32'h00300113, 1'b1);
        #1 chk("fl.ready", 32'(fetch_ready), 32'd1);
        @(negedge clk);
        flush = 1'b0; fetch_valid = 1'b0;
        check_out("fl.flushed");
        @(negedge clk);
        check_out("fl.empty");
        offer(32'h00500093, 32'h00300113, 1'b1);
        #1 chk("fl.ready_after", 32'(fetch_ready), 32'd1);
        expq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 32'h00500093, 32'h00300113});
        @(negedge clk);
        fetch_valid = 1'b0;
        @(negedge clk);
        check_out("fl.newpair");

        // Reset asserted while a split pair is half issued.
        do_reset();
        offer(32'h00500093, 32'h00108133, 1'b1);
        expq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 32'h00500093, NOP});
        expq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, NOP, NOP});
        expq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, NOP, NOP});
        @(negedge clk);
        fetch_valid = 1'b0;
        @(negedge clk);
        check_out("rs.split");
        rst = 1'b1;
        #1 chk("rs.ready_in_rst", 32'(fetch_ready), 32'd0);
        @(negedge clk);
        check_out("rs.reset");
        rst = 1'b0;
        @(negedge clk);
        check_out("rs.dropped");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
